// File: rtl/fpu_result_checker.sv
// fpu_result_checker: consumer end of the FPU test-vector path.
// Accepts FPU results over valid/ready, compares each against a loadable
// golden table in vector order, and reports match, error count and pass
// completion for the board LEDs/display.
// Optional macro FIRST_FAIL_CAPTURE_EN adds ff_valid/ff_idx/ff_data, which
// record the index and value of the first mismatch in each pass.
module fpu_result_checker #(
  parameter int NUM = 10,
  parameter int IW  = 4,
  parameter int CW  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          res_valid,
  input  logic [31:0]   res_data,
  output logic          res_ready,
  input  logic          gld_we,
  input  logic [IW-1:0] gld_addr,
  input  logic [31:0]   gld_data,
  output logic [IW-1:0] idx,
  output logic          match,
  output logic          cmp_valid,
  output logic [CW-1:0] err_count,
  output logic          done
`ifdef FIRST_FAIL_CAPTURE_EN
  ,
  output logic          ff_valid,
  output logic [IW-1:0] ff_idx,
  output logic [31:0]   ff_data
`endif
);

  localparam int                DEPTH    = 1 << IW;
  localparam logic [IW-1:0]     LAST_IDX = IW'(NUM - 1);
  localparam logic [CW-1:0]     ERR_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOOKUP  = 2'd1,
    COMPARE = 2'd2
  } state_t;

  state_t        state;
  state_t        next_state;

  logic [31:0]   golden [DEPTH];
  logic [31:0]   cap;
  logic [31:0]   gold_q;
  logic          accept;
  logic          eq;
  logic          cap_zero;
  logic          gold_zero;
  logic          cap_nan;
  logic          gold_nan;

  assign accept = res_valid && res_ready;

  // Floating-point equality: bit-exact, or both zeros of any sign, or both
  // NaNs regardless of payload. Infinities fall under the bit-exact rule.
  assign cap_zero  = (cap[30:0] == 31'd0);
  assign gold_zero = (gold_q[30:0] == 31'd0);
  assign cap_nan   = (cap[30:23] == 8'hFF) && (cap[22:0] != 23'd0);
  assign gold_nan  = (gold_q[30:23] == 8'hFF) && (gold_q[22:0] != 23'd0);
  assign eq        = (cap == gold_q) || (cap_zero && gold_zero) || (cap_nan && gold_nan);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next state; only IDLE can take a new result.
  always_comb begin
    next_state = state;
    res_ready  = 1'b0;
    case (state)
      IDLE: begin
        res_ready = 1'b1;
        if (res_valid) begin
          next_state = LOOKUP;
        end
      end
      LOOKUP: begin
        next_state = COMPARE;
      end
      COMPARE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Golden table: writable at any time, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        golden[i] <= 32'd0;
      end
    end else if (gld_we) begin
      golden[gld_addr] <= gld_data;
    end
  end

  // Capture the accepted result so the producer is free after the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap <= 32'd0;
    end else if (accept) begin
      cap <= res_data;
    end
  end

  // Registered golden read; a same-cycle write to this entry is seen next pass.
  always_ff @(posedge clk) begin
    if (rst) begin
      gold_q <= 32'd0;
    end else if (state == LOOKUP) begin
      gold_q <= golden[idx];
    end
  end

  // Result reporting, vector index, pass completion and error counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      match     <= 1'b0;
      cmp_valid <= 1'b0;
      err_count <= '0;
      done      <= 1'b0;
    end else begin
      cmp_valid <= 1'b0;
      if (accept && done) begin
        done      <= 1'b0;
        err_count <= '0;
      end
      if (state == COMPARE) begin
        match     <= eq;
        cmp_valid <= 1'b1;
        if (!eq && (err_count != ERR_MAX)) begin
          err_count <= err_count + CW'(1);
        end
        if (idx == LAST_IDX) begin
          idx  <= '0;
          done <= 1'b1;
        end else begin
          idx <= idx + IW'(1);
        end
      end
    end
  end

`ifdef FIRST_FAIL_CAPTURE_EN
  // First mismatch of a pass is held until the next pass starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      ff_valid <= 1'b0;
      ff_idx   <= '0;
      ff_data  <= 32'd0;
    end else if (accept && done) begin
      ff_valid <= 1'b0;
      ff_idx   <= '0;
      ff_data  <= 32'd0;
    end else if ((state == COMPARE) && !eq && !ff_valid) begin
      ff_valid <= 1'b1;
      ff_idx   <= idx;
      ff_data  <= cap;
    end
  end
`endif

endmodule
